// File: rtl/gpu_regfile_mp_if.sv
// Bus bundle for gpu_regfile_mp: write ports, read ports, scoreboard and clear control.
interface gpu_regfile_mp_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr0_en;
    logic [ADDR_WIDTH-1:0] wr0_addr;
    logic [DATA_WIDTH-1:0] wr0_data;
    logic                  wr1_en;
    logic [ADDR_WIDTH-1:0] wr1_addr;
    logic [DATA_WIDTH-1:0] wr1_data;
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic [DATA_WIDTH-1:0] rd_data_a;
    logic [DATA_WIDTH-1:0] rd_data_b;
    logic                  rsv_en;
    logic [ADDR_WIDTH-1:0] rsv_addr;
    logic                  busy_a;
    logic                  busy_b;
    logic                  clear_req;
    logic                  clear_busy;
    logic                  clear_done;
    logic                  wr_conflict;

    modport master (
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output rd_addr_a, rd_addr_b,
        output rsv_en, rsv_addr, clear_req,
        input  rd_data_a, rd_data_b,
        input  busy_a, busy_b,
        input  clear_busy, clear_done, wr_conflict
    );

    modport slave (
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  rd_addr_a, rd_addr_b,
        input  rsv_en, rsv_addr, clear_req,
        output rd_data_a, rd_data_b,
        output busy_a, busy_b,
        output clear_busy, clear_done, wr_conflict
    );
endinterface

// File: rtl/gpu_regfile_mp.sv
// Dual-write, dual-read GPU register file with scoreboard and sequenced clear.
// Optional macro ZERO_REG_EN hardwires register 0 to zero.
module gpu_regfile_mp #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 16,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    gpu_regfile_mp_if.slave  bus
);
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
    logic [REG_COUNT-1:0]  r_busy;
    logic [DATA_WIDTH-1:0] r_rd_a;
    logic [DATA_WIDTH-1:0] r_rd_b;
    logic                  r_clear_busy;
    logic                  r_clear_done;
    logic                  r_conflict;

    logic                  w_idle;
    logic                  w_same;
    logic                  w_nz0;
    logic                  w_nz1;
    logic                  w_nzr;
    logic                  w_wr0;
    logic                  w_wr1;
    logic                  w_rsv;
    logic                  w_conf;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;
    logic [REG_COUNT-1:0]  w_busy_nxt;

    assign w_idle = (r_state == S_IDLE);
    assign w_same = (bus.wr0_addr == bus.wr1_addr);

`ifdef ZERO_REG_EN
    assign w_nz0 = (bus.wr0_addr != '0);
    assign w_nz1 = (bus.wr1_addr != '0);
    assign w_nzr = (bus.rsv_addr != '0);
`else
    assign w_nz0 = 1'b1;
    assign w_nz1 = 1'b1;
    assign w_nzr = 1'b1;
`endif

    // Port 0 has priority; port 1 is dropped on a same-address collision.
    assign w_wr0  = w_idle & bus.wr0_en & w_nz0;
    assign w_wr1  = w_idle & bus.wr1_en & w_nz1
                  & ~(bus.wr0_en & w_same);
    assign w_rsv  = w_idle & bus.rsv_en & w_nzr;
    assign w_conf = w_idle & bus.wr0_en & bus.wr1_en
                  & w_same & w_nz0;

    always_comb begin
        w_rd_a = r_regs[bus.rd_addr_a];
        if (w_wr0 && bus.wr0_addr == bus.rd_addr_a)
            w_rd_a = bus.wr0_data;
        else if (w_wr1 && bus.wr1_addr == bus.rd_addr_a)
            w_rd_a = bus.wr1_data;
`ifdef ZERO_REG_EN
        if (bus.rd_addr_a == '0)
            w_rd_a = '0;
`endif
    end

    always_comb begin
        w_rd_b = r_regs[bus.rd_addr_b];
        if (w_wr0 && bus.wr0_addr == bus.rd_addr_b)
            w_rd_b = bus.wr0_data;
        else if (w_wr1 && bus.wr1_addr == bus.rd_addr_b)
            w_rd_b = bus.wr1_data;
`ifdef ZERO_REG_EN
        if (bus.rd_addr_b == '0)
            w_rd_b = '0;
`endif
    end

    // Reserve is applied last so a new producer outranks a retiring one.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr0)
            w_busy_nxt[bus.wr0_addr] = 1'b0;
        if (w_wr1)
            w_busy_nxt[bus.wr1_addr] = 1'b0;
        if (w_rsv)
            w_busy_nxt[bus.rsv_addr] = 1'b1;
        if (!w_idle)
            w_busy_nxt[r_cnt] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++)
                r_regs[i] <= '0;
        end else begin
            if (w_wr0)
                r_regs[bus.wr0_addr] <= bus.wr0_data;
            if (w_wr1)
                r_regs[bus.wr1_addr] <= bus.wr1_data;
            if (!w_idle)
                r_regs[r_cnt] <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy     <= '0;
            r_rd_a     <= '0;
            r_rd_b     <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_rd_a     <= w_rd_a;
            r_rd_b     <= w_rd_b;
            r_conflict <= w_conf;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.clear_req) begin
                        r_state      <= S_CLEAR;
                        r_cnt        <= '0;
                        r_clear_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == ADDR_WIDTH'(REG_COUNT - 1)) begin
                        r_state      <= S_IDLE;
                        r_cnt        <= '0;
                        r_clear_busy <= 1'b0;
                        r_clear_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_data_a   = r_rd_a;
    assign bus.rd_data_b   = r_rd_b;
    assign bus.busy_a      = r_busy[bus.rd_addr_a];
    assign bus.busy_b      = r_busy[bus.rd_addr_b];
    assign bus.clear_busy  = r_clear_busy;
    assign bus.clear_done  = r_clear_done;
    assign bus.wr_conflict = r_conflict;

endmodule

// File: doc/gpu_regfile_mp.md
Name: gpu_regfile_mp

Overview:
- Parametrised multi-port register file for the GPU core; successor to the single-write, two-read file.
- Two write ports: port 0 is ALU writeback, port 1 is load writeback.
- Two registered read ports with write-first bypass.
- Per-register scoreboard busy bits for hazard detection, plus a sequenced clear engine that zeroes the file one register per cycle.

Parameters:
- DATA_WIDTH, 16, width of each register.
- REG_COUNT, 16, number of registers; power of two, >= 2.
- ADDR_WIDTH, $clog2(REG_COUNT), register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr0_en  in  1  ALU write enable.
- wr0_addr  in  ADDR_WIDTH  ALU write index.
- wr0_data  in  DATA_WIDTH  ALU write data.
- wr1_en  in  1  load write enable.
- wr1_addr  in  ADDR_WIDTH  load write index.
- wr1_data  in  DATA_WIDTH  load write data.
- rd_addr_a  in  ADDR_WIDTH  read port A index.
- rd_addr_b  in  ADDR_WIDTH  read port B index.
- rd_data_a  out  DATA_WIDTH  registered read data A.
- rd_data_b  out  DATA_WIDTH  registered read data B.
- rsv_en  in  1  reserve (mark busy) request.
- rsv_addr  in  ADDR_WIDTH  index to reserve.
- busy_a  out  1  combinational scoreboard bit for rd_addr_a.
- busy_b  out  1  combinational scoreboard bit for rd_addr_b.
- clear_req  in  1  start clear sweep (pulse).
- clear_busy  out  1  high while the sweep runs.
- clear_done  out  1  one-cycle pulse when the sweep completes.
- wr_conflict  out  1  registered one-cycle pulse on a same-address dual write.

Behaviour:
- Reset (reset low, asynchronous):
  - All registers, busy bits, rd_data_a/b, clear_busy, clear_done and wr_conflict go to 0.
  - FSM goes to IDLE; sweep counter goes to 0.
  - Reset mid-sweep aborts it; clear_done does not pulse.
- Read ports:
  - Latency is 1 cycle: rd_data_x at cycle t+1 reflects rd_addr_x sampled at edge t.
  - Write-first bypass: if a write to rd_addr_x is accepted at edge t, rd_data_x at t+1 is the new write data.
  - Bypass priority matches write priority.
- Write ports:
  - Both ports may write different addresses in the same cycle; both take effect.
  - Same address, both enabled: port 0 wins, port 1 is dropped, and wr_conflict pulses the next cycle.
- Scoreboard:
  - rsv_en sets busy[rsv_addr].
  - An accepted write clears busy[addr] on either port.
  - Reserve and write to the same index in the same cycle: reserve wins and busy stays 1 (a new producer is outstanding).
  - busy_a/busy_b are combinational from current busy state, with no bypass.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clear_req.
  - In CLEAR, each cycle writes 0 to regs[cnt], clears busy[cnt], then cnt++.
  - After cnt = REG_COUNT-1 is written: -> IDLE, cnt = 0, clear_done = 1 for one cycle.
  - Sweep takes exactly REG_COUNT cycles; clear_busy = 1 throughout CLEAR.
  - During CLEAR: wr0/wr1/rsv are ignored (no state change, no wr_conflict); reads still return array contents through the normal registered path.
  - clear_req while in CLEAR is ignored.
- Addresses are full-range ADDR_WIDTH; no out-of-range case exists.

Optional Feature:
- Macro ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero: writes to index 0 on either port are discarded, and rd_data reads 0 for index 0.
  - busy[0] is never set.
  - Same-address dual writes to index 0 do not raise wr_conflict.
- Undefined: register 0 behaves like any other register.

Test Plan:
- Reset, then read all 16 indices -> all rd_data = 0x0000; busy_a = busy_b = 0.
- Write wr0 r3 = 0xBEEF while rd_addr_a = 3 in the same cycle -> rd_data_a = 0xBEEF on the next cycle (bypass).
- wr0 r5 = 0x1111 and wr1 r5 = 0x2222 in the same cycle -> r5 reads 0x1111; wr_conflict = 1 for exactly one cycle.
- rsv r7 -> busy for r7 = 1; then wr1 r7 = 0x00AA -> busy = 0 next cycle. Reserve and write r7 in the same cycle -> busy stays 1.
- Fill r0..r15 with nonzero values; pulse clear_req -> clear_busy high for 16 cycles, clear_done pulses once, all reads return 0. A write issued mid-sweep has no effect. Assert reset at sweep cycle 8 -> FSM IDLE, no clear_done.
- With ZERO_REG_EN defined: wr0 r0 = 0xFFFF -> rd_data_a(0) = 0; rsv r0 -> busy stays 0.
